// File: rtl/riscv_uc.sv
// riscv_uc: multi-cycle Moore control unit for the RV32 datapath.
// It steps each instruction through FETCH, DECODE, EXEC, MEM, WB and PC_UPD.
// Every output is decoded only from the state, the latched instruction class
// and the latched branch decision, so opcode and branch have no
// combinational path to any output.
module riscv_uc (
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] opcode,
   input  logic       branch,
   output logic       pc_load,
   output logic       pc_reset,
   output logic       mem_re,
   output logic       mem_we,
   output logic       reg_file_write,
   output logic [1:0] alu_op,
   output logic [1:0] select_mux_1,
   output logic [1:0] select_mux_2,
   output logic [1:0] select_mux_3,
   output logic [1:0] select_mux_4,
   output logic       instr_done,
   output logic       illegal
);

   // Opcode values of the supported instruction classes.
   localparam logic [6:0] OPC_R      = 7'b0110011;
   localparam logic [6:0] OPC_I      = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;

   // ALU op classes.
   localparam logic [1:0] ALU_ADD  = 2'b00;
   localparam logic [1:0] ALU_CMP  = 2'b01;
   localparam logic [1:0] ALU_FUNC = 2'b10;

   typedef enum logic [2:0] {
      S_INIT   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_PC_UPD = 3'd6
   } state_t;

   typedef enum logic [2:0] {
      CL_R      = 3'd0,
      CL_I      = 3'd1,
      CL_LOAD   = 3'd2,
      CL_STORE  = 3'd3,
      CL_BRANCH = 3'd4,
      CL_ILL    = 3'd5
   } iclass_t;

   state_t  state_q, state_d;
   iclass_t class_q, class_d;
   logic    taken_q, taken_d;
   iclass_t live_class;

   // Classify the live opcode; only consumed on the DECODE exit edge.
   always_comb begin
      live_class = CL_ILL;
      case (opcode)
         OPC_R:      live_class = CL_R;
         OPC_I:      live_class = CL_I;
         OPC_LOAD:   live_class = CL_LOAD;
         OPC_STORE:  live_class = CL_STORE;
         OPC_BRANCH: live_class = CL_BRANCH;
         default:    live_class = CL_ILL;
      endcase
   end

   // State, class and taken registers; reset aborts any instruction in flight.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_INIT;
         class_q <= CL_R;
         taken_q <= 1'b0;
      end else begin
         state_q <= state_d;
         class_q <= class_d;
         taken_q <= taken_d;
      end
   end

   // Next state, class capture in DECODE, branch decision capture in EXEC.
   always_comb begin
      state_d = state_q;
      class_d = class_q;
      taken_d = taken_q;
      case (state_q)
         S_INIT:   state_d = S_FETCH;
         S_FETCH:  state_d = S_DECODE;
         S_DECODE: begin
            class_d = live_class;
            state_d = (live_class == CL_ILL) ? S_PC_UPD : S_EXEC;
         end
         S_EXEC: begin
            // Only a branch carries a decision forward; every other exit clears it.
            taken_d = (class_q == CL_BRANCH) ? branch : 1'b0;
            case (class_q)
               CL_R, CL_I:         state_d = S_WB;
               CL_LOAD, CL_STORE:  state_d = S_MEM;
               default:            state_d = S_PC_UPD;
            endcase
         end
         S_MEM:    state_d = (class_q == CL_LOAD) ? S_WB : S_PC_UPD;
         S_WB:     state_d = S_PC_UPD;
         S_PC_UPD: state_d = S_FETCH;
         default:  state_d = S_INIT;
      endcase
   end

   // Moore output decode from state, latched class and taken.
   always_comb begin
      pc_load        = 1'b0;
      pc_reset       = 1'b0;
      mem_re         = 1'b0;
      mem_we         = 1'b0;
      reg_file_write = 1'b0;
      alu_op         = ALU_ADD;
      select_mux_1   = 2'b00;
      select_mux_2   = 2'b00;
      select_mux_3   = 2'b00;
      select_mux_4   = 2'b00;
      instr_done     = 1'b0;
      illegal        = 1'b0;

      // EXEC, MEM and WB all present the same ALU setup so the address or
      // result stays stable while memory and the register file consume it.
      if (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB) begin
         case (class_q)
            CL_R: begin
               alu_op       = ALU_FUNC;
               select_mux_1 = 2'b00;
            end
            CL_I: begin
               alu_op       = ALU_FUNC;
               select_mux_1 = 2'b01;
            end
            CL_LOAD, CL_STORE: begin
               alu_op       = ALU_ADD;
               select_mux_1 = 2'b01;
            end
            CL_BRANCH: begin
               alu_op       = ALU_CMP;
               select_mux_1 = 2'b00;
            end
            default: begin
               alu_op       = ALU_ADD;
               select_mux_1 = 2'b00;
            end
         endcase
      end

      case (state_q)
         S_INIT: pc_reset = 1'b1;
         S_MEM: begin
            if (class_q == CL_LOAD) begin
               mem_re = 1'b1;
            end else if (class_q == CL_STORE) begin
               mem_we       = 1'b1;
               select_mux_4 = 2'b01;
            end
         end
         S_WB: begin
            reg_file_write = 1'b1;
            if (class_q == CL_LOAD) begin
               mem_re       = 1'b1;
               select_mux_2 = 2'b01;
            end
         end
         S_PC_UPD: begin
            pc_load      = 1'b1;
            select_mux_3 = {1'b0, taken_q};
            instr_done   = 1'b1;
            illegal      = (class_q == CL_ILL);
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_riscv_uc.sv
// tb_riscv_uc: directed checks of the riscv_uc control sequence.
// Outputs are packed into one vector and compared cycle by cycle against
// hand-written expected vectors, sampled 1 ns after each rising edge.
module tb_riscv_uc;

   logic       clk;
   logic       reset;
   logic [6:0] opcode;
   logic       branch;
   logic       pc_load, pc_reset, mem_re, mem_we, reg_file_write;
   logic [1:0] alu_op, select_mux_1, select_mux_2, select_mux_3, select_mux_4;
   logic       instr_done, illegal;

   int n_chk  = 0;
   int n_pass = 0;

   localparam logic [6:0] OPC_R      = 7'b0110011;
   localparam logic [6:0] OPC_I      = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_BAD    = 7'b1110011;

   riscv_uc dut (
      .clk            (clk),
      .reset          (reset),
      .opcode         (opcode),
      .branch         (branch),
      .pc_load        (pc_load),
      .pc_reset       (pc_reset),
      .mem_re         (mem_re),
      .mem_we         (mem_we),
      .reg_file_write (reg_file_write),
      .alu_op         (alu_op),
      .select_mux_1   (select_mux_1),
      .select_mux_2   (select_mux_2),
      .select_mux_3   (select_mux_3),
      .select_mux_4   (select_mux_4),
      .instr_done     (instr_done),
      .illegal        (illegal)
   );

   // Clock: 10 ns period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Observed outputs as one vector.
   logic [16:0] obs;
   assign obs = {pc_load, pc_reset, mem_re, mem_we, reg_file_write, alu_op,
                 select_mux_1, select_mux_2, select_mux_3, select_mux_4,
                 instr_done, illegal};

   // Build an expected output vector in the same field order as obs.
   function automatic logic [16:0] ov(input logic pcl, input logic pcr,
                                      input logic re, input logic we,
                                      input logic rfw, input logic [1:0] alu,
                                      input logic [1:0] s1, input logic [1:0] s2,
                                      input logic [1:0] s3, input logic [1:0] s4,
                                      input logic done, input logic ill);
      return {pcl, pcr, re, we, rfw, alu, s1, s2, s3, s4, done, ill};
   endfunction

   localparam logic [16:0] V_ZERO = 17'd0;

   function automatic logic [16:0] v_init();
      return ov(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0);
   endfunction

   // Advance one clock and settle just after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Drive inputs for cycle index i of an instruction (0 = FETCH), then step.
   // The opcode is scrambled from cycle 2 on to show it is no longer used.
   task automatic drive_next(input int i, input logic [6:0] opc,
                             input logic br_dec, input logic br_exec,
                             input logic [6:0] scramble);
      opcode = (i < 2) ? opc : scramble;
      branch = (i == 1) ? br_dec : ((i == 2) ? br_exec : 1'b0);
      step();
   endtask

   task automatic test_reset();
      reset  = 1'b0;
      opcode = OPC_R;
      branch = 1'b0;
      #1;
      for (int i = 0; i < 3; i++) begin
         step();
         n_chk++;
         if (obs !== v_init()) $display("FAIL reset_hold[%0d]: got %b expected %b", i, obs, v_init());
         else n_pass++;
      end
      reset = 1'b1;
      #1;
      n_chk++;
      if (obs !== v_init()) $display("FAIL reset_init_cycle: got %b expected %b", obs, v_init());
      else n_pass++;
      step();
      n_chk++;
      if (obs !== V_ZERO) $display("FAIL reset_fetch: got %b expected %b", obs, V_ZERO);
      else n_pass++;
   endtask

   // R-type then I-type, 5 cycles each.
   task automatic test_r_i();
      logic [16:0] e [0:5];
      e[0] = V_ZERO;
      e[1] = V_ZERO;
      e[2] = ov(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0);
      e[3] = ov(0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0);
      e[4] = ov(1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0);
      e[5] = V_ZERO;
      for (int i = 0; i <= 5; i++) begin
         n_chk++;
         if (obs !== e[i]) $display("FAIL r_type[%0d]: got %b expected %b", i, obs, e[i]);
         else n_pass++;
         if (i < 5) drive_next(i, OPC_R, 1'b1, 1'b1, OPC_STORE);
      end
      e[2] = ov(0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 2'b00, 2'b00, 0, 0);
      e[3] = ov(0, 0, 0, 0, 1, 2'b10, 2'b01, 2'b00, 2'b00, 2'b00, 0, 0);
      for (int i = 0; i <= 5; i++) begin
         n_chk++;
         if (obs !== e[i]) $display("FAIL i_type[%0d]: got %b expected %b", i, obs, e[i]);
         else n_pass++;
         if (i < 5) drive_next(i, OPC_I, 1'b0, 1'b0, OPC_LOAD);
      end
   endtask

   // LOAD (6 cycles) then STORE (5 cycles).
   task automatic test_load_store();
      logic [16:0] e [0:6];
      e[0] = V_ZERO;
      e[1] = V_ZERO;
      e[2] = ov(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 0, 0);
      e[3] = ov(0, 0, 1, 0, 0, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 0, 0);
      e[4] = ov(0, 0, 1, 0, 1, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 0, 0);
      e[5] = ov(1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0);
      e[6] = V_ZERO;
      for (int i = 0; i <= 6; i++) begin
         n_chk++;
         if (obs !== e[i]) $display("FAIL load[%0d]: got %b expected %b", i, obs, e[i]);
         else n_pass++;
         if (i < 6) drive_next(i, OPC_LOAD, 1'b0, 1'b0, OPC_R);
      end
      e[3] = ov(0, 0, 0, 1, 0, 2'b00, 2'b01, 2'b00, 2'b00, 2'b01, 0, 0);
      e[4] = ov(1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0);
      e[5] = V_ZERO;
      for (int i = 0; i <= 5; i++) begin
         n_chk++;
         if (obs !== e[i]) $display("FAIL store[%0d]: got %b expected %b", i, obs, e[i]);
         else n_pass++;
         if (i < 5) drive_next(i, OPC_STORE, 1'b0, 1'b0, OPC_LOAD);
      end
   endtask

   // Branch taken (branch high in EXEC), then branch high only in DECODE,
   // then an I-type to show the taken flag does not leak forward.
   task automatic test_branch();
      logic [16:0] e [0:5];
      e[0] = V_ZERO;
      e[1] = V_ZERO;
      e[2] = ov(0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0);
      e[3] = ov(1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 1, 0);
      e[4] = V_ZERO;
      for (int i = 0; i <= 4; i++) begin
         n_chk++;
         if (obs !== e[i]) $display("FAIL branch_taken[%0d]: got %b expected %b", i, obs, e[i]);
         else n_pass++;
         if (i < 4) drive_next(i, OPC_BRANCH, 1'b0, 1'b1, OPC_R);
      end
      e[3] = ov(1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0);
      for (int i = 0; i <= 4; i++) begin
         n_chk++;
         if (obs !== e[i]) $display("FAIL branch_decode_pulse[%0d]: got %b expected %b", i, obs, e[i]);
         else n_pass++;
         if (i < 4) drive_next(i, OPC_BRANCH, 1'b1, 1'b0, OPC_STORE);
      end
      // Taken again, then I-type must retire with sel3 = 0.
      for (int i = 0; i < 4; i++) drive_next(i, OPC_BRANCH, 1'b0, 1'b1, OPC_BRANCH);
      e[2] = ov(0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 2'b00, 2'b00, 0, 0);
      e[3] = ov(0, 0, 0, 0, 1, 2'b10, 2'b01, 2'b00, 2'b00, 2'b00, 0, 0);
      e[4] = ov(1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0);
      e[5] = V_ZERO;
      for (int i = 0; i <= 5; i++) begin
         n_chk++;
         if (obs !== e[i]) $display("FAIL after_taken_i[%0d]: got %b expected %b", i, obs, e[i]);
         else n_pass++;
         if (i < 5) drive_next(i, OPC_I, 1'b0, 1'b1, OPC_BRANCH);
      end
   endtask

   // Unsupported opcode: 3 cycles with illegal, then a normal R-type.
   task automatic test_illegal();
      logic [16:0] e [0:5];
      e[0] = V_ZERO;
      e[1] = V_ZERO;
      e[2] = ov(1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1, 1);
      e[3] = V_ZERO;
      for (int i = 0; i <= 3; i++) begin
         n_chk++;
         if (obs !== e[i]) $display("FAIL illegal[%0d]: got %b expected %b", i, obs, e[i]);
         else n_pass++;
         if (i < 3) drive_next(i, OPC_BAD, 1'b1, 1'b1, OPC_R);
      end
      e[2] = ov(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0);
      e[3] = ov(0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0);
      e[4] = ov(1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0);
      e[5] = V_ZERO;
      for (int i = 0; i <= 5; i++) begin
         n_chk++;
         if (obs !== e[i]) $display("FAIL after_illegal_r[%0d]: got %b expected %b", i, obs, e[i]);
         else n_pass++;
         if (i < 5) drive_next(i, OPC_R, 1'b0, 1'b0, OPC_BAD);
      end
   endtask

   // Reset asserted during STORE MEM, then a complete STORE after release.
   task automatic test_mid_reset();
      logic [16:0] e [0:5];
      logic [16:0] v_mem;
      int we_cycles;
      v_mem = ov(0, 0, 0, 1, 0, 2'b00, 2'b01, 2'b00, 2'b00, 2'b01, 0, 0);
      for (int i = 0; i < 3; i++) drive_next(i, OPC_STORE, 1'b0, 1'b0, OPC_STORE);
      n_chk++;
      if (obs !== v_mem) $display("FAIL mid_reset_mem: got %b expected %b", obs, v_mem);
      else n_pass++;
      #2;
      reset = 1'b0;
      #1;
      n_chk++;
      if (obs !== v_init()) $display("FAIL mid_reset_async: got %b expected %b", obs, v_init());
      else n_pass++;
      step();
      reset = 1'b1;
      #1;
      n_chk++;
      if (obs !== v_init()) $display("FAIL mid_reset_release_init: got %b expected %b", obs, v_init());
      else n_pass++;
      step();
      e[0] = V_ZERO;
      e[1] = V_ZERO;
      e[2] = ov(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 0, 0);
      e[3] = v_mem;
      e[4] = ov(1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0);
      e[5] = V_ZERO;
      we_cycles = 0;
      for (int i = 0; i <= 5; i++) begin
         if (mem_we === 1'b1) we_cycles++;
         n_chk++;
         if (obs !== e[i]) $display("FAIL post_reset_store[%0d]: got %b expected %b", i, obs, e[i]);
         else n_pass++;
         if (i < 5) drive_next(i, OPC_STORE, 1'b0, 1'b0, OPC_STORE);
      end
      n_chk++;
      if (we_cycles !== 1) $display("FAIL post_reset_we_count: got %0d expected 1", we_cycles);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_r_i();
      test_load_store();
      test_branch();
      test_illegal();
      test_mid_reset();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
